spq_pq: RTL and testbench



---
 rtl/spq_pq_if.sv | 31 +++
 rtl/spq_pq.sv | 119 +++++++++++
 tb/tb_spq_pq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spq_pq_if.sv
// Client/queue bundle for the spq_pq priority queue: command, insert data,
// head output and status.
interface spq_pq_if #(
  parameter int DEPTH = 16,
  parameter int KW    = 16,
  parameter int VW    = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          clr;
  logic          enq;
  logic          deq;
  logic [KW-1:0] kvi_key;
  logic [VW-1:0] kvi_val;
  logic [KW-1:0] kvo_key;
  logic [VW-1:0] kvo_val;
  logic          full;
  logic          empty;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output clr, enq, deq, kvi_key, kvi_val,
    input  kvo_key, kvo_val, full, empty, busy, count
  );

  modport slave (
    input  clr, enq, deq, kvi_key, kvi_val,
    output kvo_key, kvo_val, full, empty, busy, count
  );
endinterface

// File: rtl/spq_pq.sv
// Register-array priority queue: sorted cells c[0..DEPTH-1] with c[0] as
// head; enq, deq and replace each complete in a single cycle.
module spq_pq #(
  parameter int DEPTH     = 16,
  parameter int KW        = 16,
  parameter int VW        = 16,
  parameter bit MAX_FIRST = 1'b0
) (
  input logic     clk,
  input logic     rst,
  spq_pq_if.slave pq
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [KW-1:0]    key  [DEPTH];
  logic [VW-1:0]    val  [DEPTH];
  logic [CW-1:0]    cnt;

  logic [DEPTH-1:0] nVld;
  logic [KW-1:0]    nKey [DEPTH];
  logic [VW-1:0]    nVal [DEPTH];
  logic [CW-1:0]    nCnt;

  logic [DEPTH-1:0] bt;
  logic             isFull, isEmpty, doEnq, doDeq, doRep;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CW'(DEPTH));
  assign doEnq   = pq.enq & ~pq.deq & ~isFull;
  assign doDeq   = pq.deq & ~pq.enq & ~isEmpty;
  assign doRep   = pq.enq & pq.deq & ~isEmpty;

  // Per-cell "new key is better" flags; monotone in i because cells are sorted
  always_comb begin
    bt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bt[i] = ~vld[i] | (MAX_FIRST ? (pq.kvi_key > key[i]) : (pq.kvi_key < key[i]));
    end
  end

  // Next cell contents for the decoded command.
  // Insert/replace positions come from the edges of the monotone bt vector
  // rather than an explicit priority encoder.
  always_comb begin
    nVld = vld;
    nKey = key;
    nVal = val;
    nCnt = cnt;
    if (doEnq) begin
      if (bt[0]) begin
        nVld[0] = 1'b1;
        nKey[0] = pq.kvi_key;
        nVal[0] = pq.kvi_val;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (bt[i]) begin
          if (bt[i-1]) begin
            nVld[i] = vld[i-1];
            nKey[i] = key[i-1];
            nVal[i] = val[i-1];
          end else begin
            nVld[i] = 1'b1;
            nKey[i] = pq.kvi_key;
            nVal[i] = pq.kvi_val;
          end
        end
      end
      nCnt = cnt + CW'(1);
    end else if (doDeq) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        nVld[i-1] = vld[i];
        nKey[i-1] = key[i];
        nVal[i-1] = val[i];
      end
      nVld[DEPTH-1] = 1'b0;
      nCnt = cnt - CW'(1);
    end else if (doRep) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (i != 0 && bt[i]) begin
          nVld[i] = vld[i];
        end else if (bt[i+1]) begin
          nVld[i] = 1'b1;
          nKey[i] = pq.kvi_key;
          nVal[i] = pq.kvi_val;
        end else begin
          nVld[i] = vld[i+1];
          nKey[i] = key[i+1];
          nVal[i] = val[i+1];
        end
      end
      if (!bt[DEPTH-1]) begin
        nVld[DEPTH-1] = 1'b1;
        nKey[DEPTH-1] = pq.kvi_key;
        nVal[DEPTH-1] = pq.kvi_val;
      end
    end
  end

  // Cell and occupancy registers; reset and flush only need to clear valids
  always_ff @(posedge clk) begin
    if (!rst || pq.clr) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      vld <= nVld;
      key <= nKey;
      val <= nVal;
      cnt <= nCnt;
    end
  end

  assign pq.kvo_key = isEmpty ? (MAX_FIRST ? '0 : '1) : key[0];
  assign pq.kvo_val = isEmpty ? '0 : val[0];
  assign pq.full    = isFull;
  assign pq.empty   = isEmpty;
  assign pq.busy    = 1'b0;
  assign pq.count   = cnt;
endmodule

// File: tb/tb_spq_pq.sv
// Bench for spq_pq: table vectors, directed corner sequences, and a random
// phase checked against an unordered (key, arrival) queue model.
module tb_spq_pq;
  localparam int D  = 8;
  localparam int KW = 8;
  localparam int VW = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0, enq = 1'b0, deq = 1'b0;
  logic [KW-1:0] kin = '0;
  logic [VW-1:0] vin = '0;

  int nChecks = 0;
  int nFail   = 0;
  int seqN    = 0;

  always #5 clk = ~clk;

  spq_pq_if #(.DEPTH(D), .KW(KW), .VW(VW)) ifMin ();
  spq_pq_if #(.DEPTH(D), .KW(KW), .VW(VW)) ifMax ();

  assign ifMin.clr = clr;  assign ifMax.clr = clr;
  assign ifMin.enq = enq;  assign ifMax.enq = enq;
  assign ifMin.deq = deq;  assign ifMax.deq = deq;
  assign ifMin.kvi_key = kin;  assign ifMax.kvi_key = kin;
  assign ifMin.kvi_val = vin;  assign ifMax.kvi_val = vin;

  spq_pq #(.DEPTH(D), .KW(KW), .VW(VW), .MAX_FIRST(1'b0)) dutMin (
    .clk(clk), .rst(rst), .pq(ifMin.slave));
  spq_pq #(.DEPTH(D), .KW(KW), .VW(VW), .MAX_FIRST(1'b1)) dutMax (
    .clk(clk), .rst(rst), .pq(ifMax.slave));

  typedef struct { int key; int val; int seq; } item_t;
  typedef item_t itemq_t[$];
  typedef struct { bit c; bit e; bit d; int k; int v; int eKey; int eVal; int eCnt; } vec_t;

  itemq_t m0, m1;
  vec_t   tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setIn(input bit c, input bit e, input bit d, input int k, input int v);
    clr = c; enq = e; deq = d; kin = KW'(k); vin = VW'(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic minState(input string nm, input int k, input int c);
    chk({nm, ".key"}, 32'(ifMin.kvo_key), k);
    chk({nm, ".count"}, 32'(ifMin.count), c);
    chk({nm, ".empty"}, 32'(ifMin.empty), (c == 0) ? 1 : 0);
    chk({nm, ".full"}, 32'(ifMin.full), (c == D) ? 1 : 0);
  endtask

  // Head = best key; ties go to the earliest arrival
  function automatic int headIdx(input itemq_t q, input bit maxF);
    int h;
    if (q.size() == 0) return -1;
    h = 0;
    for (int i = 1; i < q.size(); i++) begin
      if ((maxF ? (q[i].key > q[h].key) : (q[i].key < q[h].key)) ||
          (q[i].key == q[h].key && q[i].seq < q[h].seq))
        h = i;
    end
    return h;
  endfunction

  function automatic itemq_t mdlNext(input itemq_t q, input bit maxF, input bit r,
                                     input bit c, input bit e, input bit d,
                                     input int k, input int v, input int s);
    itemq_t n;
    int     h;
    n = q;
    if (!r || c) begin
      n.delete();
      return n;
    end
    if (e && !d && n.size() < D) begin
      n.push_back('{k, v, s});
    end else if (d && n.size() > 0) begin
      h = headIdx(n, maxF);
      n.delete(h);
      if (e) n.push_back('{k, v, s});
    end
    return n;
  endfunction

  task automatic checkModel(input bit maxF, input itemq_t q);
    int h, eK, eV;
    h  = headIdx(q, maxF);
    eK = (h < 0) ? (maxF ? 0 : 255) : q[h].key;
    eV = (h < 0) ? 0 : q[h].val;
    if (!maxF) begin
      chk("rnd.min.key", 32'(ifMin.kvo_key), eK);
      chk("rnd.min.val", 32'(ifMin.kvo_val), eV);
      chk("rnd.min.count", 32'(ifMin.count), q.size());
      chk("rnd.min.empty", 32'(ifMin.empty), (q.size() == 0) ? 1 : 0);
      chk("rnd.min.full", 32'(ifMin.full), (q.size() == D) ? 1 : 0);
      chk("rnd.min.busy", 32'(ifMin.busy), 0);
    end else begin
      chk("rnd.max.key", 32'(ifMax.kvo_key), eK);
      chk("rnd.max.val", 32'(ifMax.kvo_val), eV);
      chk("rnd.max.count", 32'(ifMax.count), q.size());
      chk("rnd.max.empty", 32'(ifMax.empty), (q.size() == 0) ? 1 : 0);
      chk("rnd.max.full", 32'(ifMax.full), (q.size() == D) ? 1 : 0);
      chk("rnd.max.busy", 32'(ifMax.busy), 0);
    end
  endtask

  initial begin
    // {clr, enq, deq, key, val, expected head key, head val, count} after the edge
    tbl[0]  = '{0, 1, 0, 5, 1,   5, 1, 1};
    tbl[1]  = '{0, 1, 0, 3, 2,   3, 2, 2};
    tbl[2]  = '{0, 1, 0, 9, 3,   3, 2, 3};
    tbl[3]  = '{0, 1, 0, 3, 4,   3, 2, 4};
    tbl[4]  = '{0, 0, 1, 0, 0,   3, 4, 3};
    tbl[5]  = '{0, 0, 1, 0, 0,   5, 1, 2};
    tbl[6]  = '{0, 0, 1, 0, 0,   9, 3, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 255, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 255, 0, 0};
    tbl[9]  = '{0, 1, 1, 4, 7, 255, 0, 0};
    tbl[10] = '{0, 1, 0, 7, 1,   7, 1, 1};
    tbl[11] = '{0, 1, 0, 2, 2,   2, 2, 2};
    tbl[12] = '{0, 1, 0, 4, 3,   2, 2, 3};
    tbl[13] = '{1, 1, 0, 1, 9, 255, 0, 0};
    tbl[14] = '{0, 1, 0, 1, 5,   1, 5, 1};
    tbl[15] = '{0, 0, 1, 0, 0, 255, 0, 0};

    // Reset
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    minState("reset", 255, 0);
    chk("reset.val", 32'(ifMin.kvo_val), 0);
    chk("reset.busy", 32'(ifMin.busy), 0);
    chk("reset.maxKey", 32'(ifMax.kvo_key), 0);

    // Table vectors on the min-first queue
    for (int i = 0; i < 16; i++) begin
      setIn(tbl[i].c, tbl[i].e, tbl[i].d, tbl[i].k, tbl[i].v);
      step();
      chk($sformatf("vec%0d.key", i), 32'(ifMin.kvo_key), tbl[i].eKey);
      chk($sformatf("vec%0d.val", i), 32'(ifMin.kvo_val), tbl[i].eVal);
      chk($sformatf("vec%0d.count", i), 32'(ifMin.count), tbl[i].eCnt);
      chk($sformatf("vec%0d.empty", i), 32'(ifMin.empty), (tbl[i].eCnt == 0) ? 1 : 0);
      chk($sformatf("vec%0d.full", i), 32'(ifMin.full), (tbl[i].eCnt == D) ? 1 : 0);
    end

    // Fill to DEPTH, enq while full, replace while full, drain
    for (int i = 0; i < D; i++) begin
      setIn(0, 1, 0, i, i + 16);
      step();
    end
    minState("fill", 0, D);
    setIn(0, 1, 0, 100, 50);
    step();
    minState("enqFull", 0, D);
    setIn(0, 1, 1, 100, 50);
    step();
    minState("repFull", 1, D);
    for (int i = 2; i < D; i++) begin
      setIn(0, 0, 1, 0, 0);
      step();
      minState($sformatf("drain%0d", i), i, D - i + 1);
    end
    setIn(0, 0, 1, 0, 0);
    step();
    minState("drainLast", 100, 1);
    chk("drainLast.val", 32'(ifMin.kvo_val), 50);
    step();
    minState("drainEmpty", 255, 0);

    // Queue {2,6,8}: replace 7, then replace 1
    setIn(0, 1, 0, 2, 0); step();
    setIn(0, 1, 0, 6, 0); step();
    setIn(0, 1, 0, 8, 0); step();
    setIn(0, 1, 1, 7, 1); step();
    minState("rep7", 6, 3);
    setIn(0, 1, 1, 1, 2); step();
    minState("rep1", 1, 3);
    setIn(0, 0, 1, 0, 0); step();
    minState("rep.deq1", 7, 2);
    step();
    minState("rep.deq2", 8, 1);
    setIn(1, 0, 0, 0, 0); step();

    // Max-first ordering
    setIn(0, 1, 0, 5, 0); step();
    setIn(0, 1, 0, 3, 0); step();
    setIn(0, 1, 0, 9, 0); step();
    chk("max.head9", 32'(ifMax.kvo_key), 9);
    setIn(0, 0, 1, 0, 0); step();
    chk("max.head5", 32'(ifMax.kvo_key), 5);
    step();
    chk("max.head3", 32'(ifMax.kvo_key), 3);
    step();
    chk("max.emptyKey", 32'(ifMax.kvo_key), 0);
    chk("max.empty", 32'(ifMax.empty), 1);

    // Flush beats enq; reset beats enq
    setIn(0, 1, 0, 4, 0); step();
    setIn(0, 1, 0, 5, 0); step();
    setIn(0, 1, 0, 6, 0); step();
    setIn(1, 1, 0, 1, 0); step();
    minState("clrEnq", 255, 0);
    setIn(0, 1, 0, 4, 0); step();
    setIn(0, 1, 0, 5, 0); step();
    rst = 1'b0;
    setIn(0, 1, 0, 1, 0); step();
    rst = 1'b1;
    minState("rstEnq", 255, 0);
    chk("rstEnq.maxCount", 32'(ifMax.count), 0);

    // Random phase against the model
    m0.delete();
    m1.delete();
    for (int n = 0; n < 1500; n++) begin
      bit r, c, e, d;
      int k, v;
      r = ($urandom_range(0, 99) != 0);
      c = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      k = $urandom_range(0, 15);
      v = $urandom_range(0, 255);
      rst = r;
      setIn(c, e, d, k, v);
      step();
      seqN++;
      m0 = mdlNext(m0, 1'b0, r, c, e, d, k, v, seqN);
      m1 = mdlNext(m1, 1'b1, r, c, e, d, k, v, seqN);
      checkModel(1'b0, m0);
      checkModel(1'b1, m1);
    end
    rst = 1'b1;
    setIn(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
